// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          WORD_SHIFT = 2;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, and with neither asserted the contents hold.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  logic [31:0] pc_q, pc4_q, inst_q;
  logic        valid_q;

  // A flush only invalidates; the PC fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      pc4_q   <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      pc4_q   <= pc_i + 32'd4;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end

  assign id_pc_o       = pc_q;
  assign id_pc_plus4_o = pc4_q;
  assign id_inst_o     = inst_q;
  assign id_valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, halt FSM, redirect/stall priority and the retired-fetch counter.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        misalign,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         mis_q, mis_d;
  logic         load, flush;

  // Priority in FETCH: halt > redirect > stall > sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (halt) begin
          flush   = 1'b1;
          state_d = ST_HALTED;
        end else if (redirect) begin
          pc_d = {redirect_pc[31:2], 2'b00};
          if (redirect_pc[1:0] != 2'b00) mis_d = 1'b1;
          if (DELAY_SLOT) load  = 1'b1;
          else            flush = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .flush_i      (flush),
    .pc_i         (pc_q),
    .inst_i       (rom_inst),
    .id_pc_o      (id_pc),
    .id_pc_plus4_o(id_pc_plus4),
    .id_inst_o    (id_inst),
    .id_valid_o   (id_valid)
  );

  // Purely combinational so the address is stable across the ROM's negedge sample.
  assign rom_addr    = pc_q >> WORD_SHIFT;
  assign if_pc       = pc_q;
  assign misalign    = mis_q;
  assign halted      = (state_q == ST_HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench: one DUT without and one with a delay slot, sharing stimulus.
module tb_if_fetch_stage;

  typedef struct {
    string       tag;
    logic [31:0] id_pc;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] cnt;
    logic        mis;
    logic        hlt;
  } exp_t;

  logic        clk, rst, stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr0, rom_inst0, if_pc0, id_pc0, id_pc4_0, id_inst0, cnt0;
  logic [31:0] rom_addr1, rom_inst1, if_pc1, id_pc1, id_pc4_1, id_inst1, cnt1;
  logic        id_valid0, mis0, hlt0, id_valid1, mis1, hlt1;

  int total = 0;
  int bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  if_fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .rom_addr(rom_addr0), .rom_inst(rom_inst0), .if_pc(if_pc0), .id_pc(id_pc0),
    .id_pc_plus4(id_pc4_0), .id_inst(id_inst0), .id_valid(id_valid0), .misalign(mis0),
    .halted(hlt0), .fetch_count(cnt0));

  if_fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .rom_addr(rom_addr1), .rom_inst(rom_inst1), .if_pc(if_pc1), .id_pc(id_pc1),
    .id_pc_plus4(id_pc4_1), .id_inst(id_inst1), .id_valid(id_valid1), .misalign(mis1),
    .halted(hlt1), .fetch_count(cnt1));

  function automatic logic [31:0] rw(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Negedge-registered ROMs, 64 words aliased over the address space.
  always @(negedge clk) begin
    rom_inst0 <= rw(int'(rom_addr0[5:0]));
    rom_inst1 <= rw(int'(rom_addr1[5:0]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string tag, input logic [31:0] idpc, input logic [31:0] inst,
                              input logic v, input logic [31:0] ifpc, input logic [31:0] cnt,
                              input logic mis, input logic hlt);
    exp_t e;
    e.tag = tag; e.id_pc = idpc; e.inst = inst; e.valid = v;
    e.if_pc = ifpc; e.cnt = cnt; e.mis = mis; e.hlt = hlt;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(input exp_t e, input logic [31:0] idpc, input logic [31:0] idpc4,
                       input logic [31:0] inst, input logic v, input logic [31:0] ifpc,
                       input logic [31:0] ra, input logic [31:0] cnt, input logic mis,
                       input logic hlt);
    cmp({e.tag, ".valid"}, 32'(v), 32'(e.valid));
    cmp({e.tag, ".inst"}, inst, e.valid ? e.inst : 32'h0);
    if (e.valid) begin
      cmp({e.tag, ".id_pc"}, idpc, e.id_pc);
      cmp({e.tag, ".id_pc4"}, idpc4, e.id_pc + 32'd4);
    end
    cmp({e.tag, ".if_pc"}, ifpc, e.if_pc);
    cmp({e.tag, ".rom_addr"}, ra, e.if_pc >> 2);
    cmp({e.tag, ".cnt"}, cnt, e.cnt);
    cmp({e.tag, ".mis"}, 32'(mis), 32'(e.mis));
    cmp({e.tag, ".halted"}, 32'(hlt), 32'(e.hlt));
  endtask

  task automatic pop_check();
    exp_t e;
    e = q0.pop_front();
    check(e, id_pc0, id_pc4_0, id_inst0, id_valid0, if_pc0, rom_addr0, cnt0, mis0, hlt0);
    e = q1.pop_front();
    check(e, id_pc1, id_pc4_1, id_inst1, id_valid1, if_pc1, rom_addr1, cnt1, mis1, hlt1);
  endtask

  // Drive one cycle of inputs, queue expectations for both DUTs, clock, then compare.
  task automatic step(input logic st, input logic rd, input logic [31:0] rp, input logic hl,
                      input exp_t e0, input exp_t e1);
    stall = st; redirect = rd; redirect_pc = rp; halt = hl;
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #1 rst = 1'b1;
    #2;
    q0.push_back(mk("rst", 0, 0, 0, 32'h0, 0, 0, 0));
    q1.push_back(mk("rst1", 0, 0, 0, 32'h0, 0, 0, 0));
    pop_check();
    cmp("rst.id_pc", id_pc0, 32'h0);
    cmp("rst.id_pc4", id_pc4_0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // free run, then two stall cycles holding B@4
    step(0, 0, 0, 0, mk("e1", 32'h0, rw(0), 1, 32'h4, 1, 0, 0), mk("e1d", 32'h0, rw(0), 1, 32'h4, 1, 0, 0));
    step(0, 0, 0, 0, mk("e2", 32'h4, rw(1), 1, 32'h8, 2, 0, 0), mk("e2d", 32'h4, rw(1), 1, 32'h8, 2, 0, 0));
    step(1, 0, 0, 0, mk("st1", 32'h4, rw(1), 1, 32'h8, 2, 0, 0), mk("st1d", 32'h4, rw(1), 1, 32'h8, 2, 0, 0));
    step(1, 0, 0, 0, mk("st2", 32'h4, rw(1), 1, 32'h8, 2, 0, 0), mk("st2d", 32'h4, rw(1), 1, 32'h8, 2, 0, 0));
    step(0, 0, 0, 0, mk("e5", 32'h8, rw(2), 1, 32'hC, 3, 0, 0), mk("e5d", 32'h8, rw(2), 1, 32'hC, 3, 0, 0));
    step(0, 0, 0, 0, mk("e6", 32'hC, rw(3), 1, 32'h10, 4, 0, 0), mk("e6d", 32'hC, rw(3), 1, 32'h10, 4, 0, 0));

    // redirect to 0x20: flush vs delay slot
    step(0, 1, 32'h20, 0, mk("rd", 0, 0, 0, 32'h20, 4, 0, 0), mk("rdd", 32'h10, rw(4), 1, 32'h20, 5, 0, 0));
    step(0, 0, 0, 0, mk("rd+1", 32'h20, rw(8), 1, 32'h24, 5, 0, 0), mk("rd+1d", 32'h20, rw(8), 1, 32'h24, 6, 0, 0));

    // misaligned redirect with stall: stall ignored, misalign sticky
    step(1, 1, 32'h22, 0, mk("mis", 0, 0, 0, 32'h20, 5, 1, 0), mk("misd", 32'h24, rw(9), 1, 32'h20, 7, 1, 0));
    step(0, 0, 0, 0, mk("mis+1", 32'h20, rw(8), 1, 32'h24, 6, 1, 0), mk("mis+1d", 32'h20, rw(8), 1, 32'h24, 8, 1, 0));
    step(0, 0, 0, 0, mk("mis+2", 32'h24, rw(9), 1, 32'h28, 7, 1, 0), mk("mis+2d", 32'h24, rw(9), 1, 32'h28, 9, 1, 0));

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, mk("wr", 0, 0, 0, 32'hFFFF_FFFC, 7, 1, 0),
         mk("wrd", 32'h28, rw(10), 1, 32'hFFFF_FFFC, 10, 1, 0));
    step(0, 0, 0, 0, mk("wr+1", 32'hFFFF_FFFC, rw(63), 1, 32'h0, 8, 1, 0),
         mk("wr+1d", 32'hFFFF_FFFC, rw(63), 1, 32'h0, 11, 1, 0));
    step(0, 0, 0, 0, mk("wr+2", 32'h0, rw(0), 1, 32'h4, 9, 1, 0), mk("wr+2d", 32'h0, rw(0), 1, 32'h4, 12, 1, 0));
    step(0, 0, 0, 0, mk("wr+3", 32'h4, rw(1), 1, 32'h8, 10, 1, 0), mk("wr+3d", 32'h4, rw(1), 1, 32'h8, 13, 1, 0));
    step(0, 0, 0, 0, mk("wr+4", 32'h8, rw(2), 1, 32'hC, 11, 1, 0), mk("wr+4d", 32'h8, rw(2), 1, 32'hC, 14, 1, 0));

    // halt at 0xC wins over a simultaneous redirect, then inputs are ignored
    step(0, 1, 32'h40, 1, mk("halt", 0, 0, 0, 32'hC, 11, 1, 1), mk("haltd", 0, 0, 0, 32'hC, 14, 1, 1));
    for (int i = 0; i < 5; i++) begin
      step(i[0], ~i[0], 32'h80 + 32'(i), 1'b0, mk("hold", 0, 0, 0, 32'hC, 11, 1, 1),
           mk("holdd", 0, 0, 0, 32'hC, 14, 1, 1));
    end

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    q0.push_back(mk("arst", 0, 0, 0, 32'h0, 0, 0, 0));
    q1.push_back(mk("arstd", 0, 0, 0, 32'h0, 0, 0, 0));
    pop_check();
    cmp("arst.id_pc", id_pc1, 32'h0);
    cmp("arst.id_pc4", id_pc4_1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the stalling pipelined MIPS CPU. Owns the program counter, drives the word address into the negedge-registered instruction ROM, and captures the returned word into the IF/ID pipeline register. Handles load-use stalls from the hazard unit, branch/jump redirects from ID, and a halt request. Also keeps a retired-fetch counter for debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DELAY_SLOT, 0: 0 flushes the IF instruction on redirect; 1 keeps it as a delay slot.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- redirect  in  1  branch/jump taken in ID.
- redirect_pc  in  32  byte target of redirect.
- halt  in  1  stop fetching until reset.
- rom_addr  out  32  word address to ROM, {2'b00, pc[31:2]}.
- rom_inst  in  32  ROM data, valid by each posedge for the current rom_addr.
- if_pc  out  32  current fetch PC.
- id_pc  out  32  PC of instruction in ID.
- id_pc_plus4  out  32  id_pc + 4.
- id_inst  out  32  instruction in ID; 0 (NOP) when invalid.
- id_valid  out  1  ID holds a real instruction.
- misalign  out  1  sticky: a redirect target had bits [1:0] ≠ 0.
- halted  out  1  FSM in HALTED.
- fetch_count  out  32  count of valid instructions loaded into ID.

## Operation
- FSM: FETCH, HALTED. Reset enters FETCH. FETCH→HALTED on halt. HALTED exits only on rst.
- Per-edge priority in FETCH: halt > redirect > stall > normal.
  - halt: pc held; id_inst←0, id_valid←0; next state HALTED.
  - redirect: pc←{redirect_pc[31:2],2'b00}. If DELAY_SLOT=0: id_inst←0, id_valid←0. If DELAY_SLOT=1: IF/ID loads the current if_pc/rom_inst as normal. misalign←1 if redirect_pc[1:0]≠0. A simultaneous stall is ignored.
  - stall only: pc, id_pc, id_pc_plus4, id_inst, id_valid all hold.
  - normal: id_pc←pc, id_pc_plus4←pc+4, id_inst←rom_inst, id_valid←1, pc←pc+4.
- HALTED: pc held; id_valid=0, id_inst=0. All inputs except rst are ignored.
- fetch_count increments by 1 on every edge where id_valid is loaded with 1. It wraps at 2^32.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 = 0.
- rom_addr is a purely combinational function of the pc register, so it is stable from posedge through the ROM's negedge sample.

## Timing
- Reset values: pc=RESET_PC, if_pc=RESET_PC, rom_addr=RESET_PC>>2, id_pc=0, id_pc_plus4=0, id_inst=0, id_valid=0, misalign=0, halted=0, fetch_count=0.
- ROM latency is half a cycle (negedge register). The word for if_pc is present at the next posedge, giving an effective 1-cycle IF→ID latency.
- After rst deasserts, the first posedge loads ID with the instruction at RESET_PC.
- A redirect asserted in cycle n makes the target appear in ID at edge n+2.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- halted rises on the edge after halt is sampled.

## Structure
- Shared cpu package holds: NOP_INST=32'h0, the FSM state encoding, and the word-address shift constant (2).
- One sub-module, if_id_reg, is natural: IF/ID register with load, hold, and flush controls. The top level holds PC, FSM, priority logic, and counter.

## Test plan
- Reset then free-run 4 cycles, ROM[0..3]=A,B,C,D → ID shows A@0, B@4, C@8, D@0xC; fetch_count=4; rom_addr counts 0,1,2,3,4.
- stall high for 2 cycles while ID holds B@4 → ID keeps B@4, if_pc holds 8, fetch_count unchanged; normal flow resumes with C@8.
- DELAY_SLOT=0, redirect to 0x20 while if_pc=8 → next edge id_valid=0, id_inst=0, pc=0x20; following edge ID holds ROM[8]@0x20.
- DELAY_SLOT=1, same redirect → ID gets C@8 (delay slot), then ROM[8]@0x20.
- redirect_pc=0x22 with stall=1 → pc=0x20, misalign=1 and stays 1 until rst; stall ignored.
- halt at if_pc=0xC → halted=1 next edge; id_valid=0; pc frozen at 0xC through 5 further cycles with stall/redirect toggling; async rst mid-cycle → all outputs at reset values immediately.
